// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundles the hazard-detection inputs and the stage-register
//                control outputs of the pipeline hazard controller.
//                slave  - seen by hazard_ctrl (hazard info in, enables out)
//                master - seen by the pipeline datapath (hazard info out,
//                         enables in)
//  Ports       : id_rs1_addr/id_rs2_addr/id_uses_rs1/id_uses_rs2 - ID operands
//                ex_mem_read/ex_rd/ex_redirect/ex_target        - EX info
//                imem_resp/dmem_req/dmem_resp                   - memories
//                load_*/flush_*/redirect_vld/redirect_pc        - controls
//                stall_count                                    - perf counter
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1_addr;
   logic [4:0]       id_rs2_addr;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic             ex_mem_read;
   logic [4:0]       ex_rd;
   logic             ex_redirect;
   logic [31:0]      ex_target;
   logic             imem_resp;
   logic             dmem_req;
   logic             dmem_resp;
   logic             load_pc;
   logic             redirect_vld;
   logic [31:0]      redirect_pc;
   logic             load_if_id;
   logic             flush_if_id;
   logic             load_id_ex;
   logic             flush_id_ex;
   logic             load_ex_mem;
   logic             load_mem_wb;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
      output ex_mem_read, ex_rd, ex_redirect, ex_target,
      output imem_resp, dmem_req, dmem_resp,
      input  load_pc, redirect_vld, redirect_pc,
      input  load_if_id, flush_if_id, load_id_ex, flush_id_ex,
      input  load_ex_mem, load_mem_wb, stall_count
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
      input  ex_mem_read, ex_rd, ex_redirect, ex_target,
      input  imem_resp, dmem_req, dmem_resp,
      output load_pc, redirect_vld, redirect_pc,
      output load_if_id, flush_if_id, load_id_ex, flush_id_ex,
      output load_ex_mem, load_mem_wb, stall_count
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard control. Generates load/flush enables for
//                the IF_ID, ID_EX, EX_MEM, MEM_WB stage registers and the PC.
//                Handles D-memory wait freezes, EX-stage redirects (with a
//                held target when the fetch is still outstanding), load-use
//                stalls and I-memory fetch waits. Counts stalled cycles in a
//                saturating counter.
//  Ports       : clk - clock, rst - synchronous active-high reset,
//                hz  - hazard_ctrl_if.slave (hazard inputs, control outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  wire logic    clk,
   input  wire logic    rst,
   hazard_ctrl_if.slave hz
);

   typedef enum logic [0:0] {
      ST_RUN        = 1'b0,
      ST_REDIR_WAIT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      tgt_q, tgt_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic dmem_busy;
   logic load_use;
   logic stall;

   always_comb begin
      dmem_busy = hz.dmem_req & ~hz.dmem_resp;
      load_use  = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                  ((hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_rd)) |
                   (hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_rd)));

      state_d         = state_q;
      tgt_d           = tgt_q;
      stall_count_d   = stall_count_q;
      stall           = 1'b0;
      hz.load_pc      = 1'b0;
      hz.redirect_vld = 1'b0;
      hz.load_if_id   = 1'b0;
      hz.flush_if_id  = 1'b0;
      hz.load_id_ex   = 1'b0;
      hz.flush_id_ex  = 1'b0;
      hz.load_ex_mem  = 1'b0;
      hz.load_mem_wb  = 1'b0;

      if (dmem_busy) begin
         // Full freeze: a redirect sitting in EX stays there and is taken
         // once the data access completes.
         stall = 1'b1;
      end else if (state_q == ST_REDIR_WAIT) begin
         // ID_EX only holds bubbles here, so ex_redirect cannot be real.
         stall          = 1'b1;
         hz.flush_id_ex = 1'b1;
         hz.load_ex_mem = 1'b1;
         hz.load_mem_wb = 1'b1;
         if (hz.imem_resp) begin
            // The word fetched from the stale PC is dropped.
            hz.flush_if_id  = 1'b1;
            hz.load_pc      = 1'b1;
            hz.redirect_vld = 1'b1;
            state_d         = ST_RUN;
         end
      end else if (hz.ex_redirect) begin
         hz.flush_if_id = 1'b1;
         hz.flush_id_ex = 1'b1;
         hz.load_ex_mem = 1'b1;
         hz.load_mem_wb = 1'b1;
         if (hz.imem_resp) begin
            hz.load_pc      = 1'b1;
            hz.redirect_vld = 1'b1;
            hz.load_if_id   = 1'b1;
            hz.load_id_ex   = 1'b1;
         end else begin
            // PC cannot move until the outstanding fetch returns; park
            // the target and apply it on the response.
            stall   = 1'b1;
            tgt_d   = hz.ex_target;
            state_d = ST_REDIR_WAIT;
         end
      end else if (load_use) begin
         stall          = 1'b1;
         hz.flush_id_ex = 1'b1;
         hz.load_ex_mem = 1'b1;
         hz.load_mem_wb = 1'b1;
      end else if (!hz.imem_resp) begin
         stall          = 1'b1;
         hz.flush_id_ex = 1'b1;
         hz.load_ex_mem = 1'b1;
         hz.load_mem_wb = 1'b1;
      end else begin
         hz.load_pc     = 1'b1;
         hz.load_if_id  = 1'b1;
         hz.load_id_ex  = 1'b1;
         hz.load_ex_mem = 1'b1;
         hz.load_mem_wb = 1'b1;
      end

      if (rst) begin
         // Enables are forced low for the whole reset cycle.
         state_d         = ST_RUN;
         tgt_d           = 32'd0;
         stall_count_d   = '0;
         hz.load_pc      = 1'b0;
         hz.redirect_vld = 1'b0;
         hz.load_if_id   = 1'b0;
         hz.flush_if_id  = 1'b0;
         hz.load_id_ex   = 1'b0;
         hz.flush_id_ex  = 1'b0;
         hz.load_ex_mem  = 1'b0;
         hz.load_mem_wb  = 1'b0;
      end else if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   assign hz.redirect_pc = (state_q == ST_RUN) ? hz.ex_target : tgt_q;
   assign hz.stall_count = stall_count_q;

   always_ff @(posedge clk) begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      stall_count_q <= stall_count_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Directed scenarios
//                followed by random stimulus, compared each cycle against a
//                table-driven reference model of the control behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int CNT_W   = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // Scenario codes used by the reference model.
   localparam int SC_RESET  = 0;
   localparam int SC_FREEZE = 1;
   localparam int SC_RD_HIT = 2;
   localparam int SC_RD_MIS = 3;
   localparam int SC_WAIT   = 4;
   localparam int SC_WAIT_R = 5;
   localparam int SC_LDUSE  = 6;
   localparam int SC_FETCH  = 7;
   localparam int SC_NORMAL = 8;

   logic clk = 1'b0;
   logic rst;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          m_wait = 1'b0;
   logic [31:0] m_tgt  = 32'd0;
   int          m_cnt  = 0;

   // Expected {load_pc, redirect_vld, load_if_id, flush_if_id,
   //           load_id_ex, flush_id_ex, load_ex_mem, load_mem_wb}
   function automatic logic [7:0] expect_vec(input int s);
      case (s)
         SC_RD_HIT: return 8'b1111_1111;
         SC_RD_MIS: return 8'b0001_0111;
         SC_WAIT:   return 8'b0000_0111;
         SC_WAIT_R: return 8'b1101_0111;
         SC_LDUSE:  return 8'b0000_0111;
         SC_FETCH:  return 8'b0000_0111;
         SC_NORMAL: return 8'b1010_1011;
         default:   return 8'b0000_0000;
      endcase
   endfunction

   function automatic int scenario();
      bit hit;
      hit = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
            ((hz.id_uses_rs1 && hz.id_rs1_addr == hz.ex_rd) ||
             (hz.id_uses_rs2 && hz.id_rs2_addr == hz.ex_rd));
      if (rst)                          return SC_RESET;
      if (hz.dmem_req && !hz.dmem_resp) return SC_FREEZE;
      if (m_wait)                       return hz.imem_resp ? SC_WAIT_R : SC_WAIT;
      if (hz.ex_redirect)               return hz.imem_resp ? SC_RD_HIT : SC_RD_MIS;
      if (hit)                          return SC_LDUSE;
      if (!hz.imem_resp)                return SC_FETCH;
      return SC_NORMAL;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hz.id_rs1_addr = 5'd1;
      hz.id_rs2_addr = 5'd2;
      hz.id_uses_rs1 = 1'b0;
      hz.id_uses_rs2 = 1'b0;
      hz.ex_mem_read = 1'b0;
      hz.ex_rd       = 5'd0;
      hz.ex_redirect = 1'b0;
      hz.ex_target   = 32'h0000_0100;
      hz.imem_resp   = 1'b1;
      hz.dmem_req    = 1'b0;
      hz.dmem_resp   = 1'b0;
   endtask

   // Inputs are already applied (posedge+1); check at posedge+3, then
   // advance the model and move to posedge+1 of the next cycle.
   task automatic step(input string tag);
      int          s;
      logic [7:0]  o;
      logic [31:0] pc_exp;
      #2;
      s      = scenario();
      o      = {hz.load_pc, hz.redirect_vld, hz.load_if_id, hz.flush_if_id,
                hz.load_id_ex, hz.flush_id_ex, hz.load_ex_mem, hz.load_mem_wb};
      pc_exp = m_wait ? m_tgt : hz.ex_target;
      chk({tag, "/ctl"}, 64'(o), 64'(expect_vec(s)));
      chk({tag, "/pc"},  64'(hz.redirect_pc), 64'(pc_exp));
      chk({tag, "/cnt"}, 64'(hz.stall_count), 64'(m_cnt));
      if (s == SC_RESET) begin
         m_wait = 1'b0;
         m_tgt  = 32'd0;
         m_cnt  = 0;
      end else begin
         if (s != SC_RD_HIT && s != SC_NORMAL && m_cnt < CNT_MAX) m_cnt++;
         if (s == SC_RD_MIS) begin
            m_wait = 1'b1;
            m_tgt  = hz.ex_target;
         end
         if (s == SC_WAIT_R) m_wait = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      // Reset, including with a redirect asserted
      step("reset0");
      hz.ex_redirect = 1'b1;
      step("reset_redir");
      rst = 1'b0;
      idle();
      step("normal");

      // Load-use on rs1: lw x5 in EX, add x6,x5,x1 in ID
      hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5;
      hz.id_rs1_addr = 5'd5; hz.id_uses_rs1 = 1'b1;
      hz.id_rs2_addr = 5'd1; hz.id_uses_rs2 = 1'b1;
      step("lu_rs1");
      idle();
      hz.id_rs1_addr = 5'd5; hz.id_uses_rs1 = 1'b1;
      step("lu_after");
      // Load-use on rs2
      hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7;
      hz.id_rs2_addr = 5'd7; hz.id_uses_rs2 = 1'b1;
      step("lu_rs2");
      // Load to x0 never stalls
      idle();
      hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0;
      hz.id_rs1_addr = 5'd0; hz.id_uses_rs1 = 1'b1;
      step("lu_x0");
      // Matching index but operand not read
      idle();
      hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5;
      hz.id_rs1_addr = 5'd5; hz.id_rs2_addr = 5'd5;
      step("lu_unused");

      // Data-memory stall for three cycles
      idle();
      hz.dmem_req = 1'b1;
      for (int i = 0; i < 3; i++) step("dstall");
      hz.dmem_resp = 1'b1;
      step("dstall_done");

      // Redirect with fetch complete
      idle();
      hz.ex_redirect = 1'b1; hz.ex_target = 32'h60;
      step("redir_hit");

      // Redirect while fetch outstanding
      hz.ex_target = 32'h80; hz.imem_resp = 1'b0;
      step("redir_miss");
      hz.ex_redirect = 1'b0; hz.ex_target = 32'h1234;
      step("rwait0");
      hz.ex_redirect = 1'b1;
      step("rwait1");
      hz.imem_resp = 1'b1;
      step("rwait_resp");
      idle();
      step("after_rwait");

      // Freeze with redirect and load-use pending, then redirect taken
      hz.dmem_req = 1'b1; hz.ex_redirect = 1'b1; hz.ex_target = 32'hA0;
      hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3;
      hz.id_rs1_addr = 5'd3; hz.id_uses_rs1 = 1'b1;
      step("freeze0");
      step("freeze1");
      hz.dmem_resp = 1'b1;
      step("unfreeze_redir");

      // Reset in the redirect wait state
      idle();
      hz.ex_redirect = 1'b1; hz.ex_target = 32'hC0; hz.imem_resp = 1'b0;
      step("rw_enter");
      idle();
      rst = 1'b1;
      step("rw_reset");
      rst = 1'b0;
      step("rw_after_reset");

      // Random stimulus
      for (int n = 0; n < 400; n++) begin
         rst            = ($urandom_range(0, 59) == 0);
         hz.id_rs1_addr = 5'($urandom_range(0, 3));
         hz.id_rs2_addr = 5'($urandom_range(0, 3));
         hz.id_uses_rs1 = 1'($urandom);
         hz.id_uses_rs2 = 1'($urandom);
         hz.ex_mem_read = 1'($urandom);
         hz.ex_rd       = 5'($urandom_range(0, 3));
         hz.ex_redirect = ($urandom_range(0, 4) == 0);
         hz.ex_target   = {$urandom} & 32'hFFFF_FFFC;
         hz.imem_resp   = ($urandom_range(0, 9) < 7);
         hz.dmem_req    = ($urandom_range(0, 3) == 0);
         hz.dmem_resp   = 1'($urandom);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
